// File: rtl/dram_ctrl_gen2.sv
// 68000-bus DRAM controller: row/column address mux, per-bank /RAS, shared /CAS,
// byte write enables, /OE, and CAS-before-RAS refresh driven by a pending-request counter.
module dram_ctrl_gen2 #(
  parameter int unsigned RAW    = 10,
  parameter int unsigned BANKW  = 1,
  parameter int unsigned REFDIV = 200,
  parameter int unsigned REFMAX = 4,
  parameter int unsigned REFURG = 2,
  parameter int unsigned TRAS   = 2,
  parameter int unsigned TRP    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2*RAW+BANKW:1]           a,
  input  logic                           n_we,
  input  logic                           n_as,
  input  logic                           n_lds,
  input  logic                           n_uds,
  input  logic                           n_dtack,
  input  logic                           bact,
  input  logic                           ramcs,
  output logic [RAW-1:0]                 ra,
  output logic [(2**BANKW)-1:0]          n_ras,
  output logic                           n_cas,
  output logic                           n_lwe,
  output logic                           n_uwe,
  output logic                           n_oe,
  output logic                           ram_ready,
  output logic [$clog2(REFMAX+1)-1:0]    ref_pend
);

  localparam int unsigned NBANK = 2**BANKW;
  localparam int unsigned PW    = $clog2(REFMAX+1);
  localparam int unsigned TW    = $clog2(REFDIV);
  localparam int unsigned CMAX  = (TRAS > TRP) ? TRAS : TRP;
  localparam int unsigned CW    = $clog2(CMAX+1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_HOLD, S_REF_CAS, S_REF_RAS, S_PRE
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [TW-1:0]      tmr;
  logic [PW-1:0]      pend_nx;
  logic               dtack_r;
  logic               rasel, rasel_nx;
  logic [NBANK-1:0]   n_ras_nx;
  logic               n_cas_nx, n_lwe_nx, n_uwe_nx, n_oe_nx, ready_nx;
  logic [RAW-1:0]     ra_nx;
  logic               tick, dec, urgent;
  logic [RAW-1:0]     col, row;
  logic [BANKW-1:0]   bank;

  assign col    = a[RAW:1];
  assign row    = a[2*RAW:RAW+1];
  assign bank   = a[2*RAW+BANKW:2*RAW+1];
  assign tick   = (tmr == TW'(REFDIV-1));
  assign dec    = (state == S_REF_CAS);
  assign urgent = (ref_pend >= PW'(REFURG));

  // Pending-refresh counter: tick and refresh start in the same cycle cancel out
  always_comb begin
    pend_nx = ref_pend;
    if (tick && !dec && (ref_pend != PW'(REFMAX)))
      pend_nx = ref_pend + PW'(1);
    else if (dec && !tick)
      pend_nx = ref_pend - PW'(1);
  end

  // Next-state and next-output logic; outputs hold unless a transition changes them
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    rasel_nx = rasel;
    n_ras_nx = n_ras;
    n_cas_nx = n_cas;
    n_lwe_nx = n_lwe;
    n_uwe_nx = n_uwe;
    ready_nx = ram_ready;
    unique case (state)
      S_IDLE: begin
        if (urgent || ((ref_pend != '0) && !bact)) begin
          state_nx = S_REF_CAS;
          n_cas_nx = 1'b0;
          ready_nx = 1'b0;
        end else if (bact && ramcs) begin
          state_nx = S_ROW;
          n_ras_nx = ~(NBANK'(1) << bank);
        end
      end
      S_ROW: begin
        state_nx = S_COL;
        rasel_nx = 1'b1;
        n_cas_nx = 1'b0;
        n_lwe_nx = !(!n_lds && !n_we);
        n_uwe_nx = !(!n_uds && !n_we);
      end
      S_COL: state_nx = S_HOLD;
      S_HOLD: begin
        // Normal end on DTACK, or early release when /AS aborts the cycle
        if (dtack_r || n_as) begin
          state_nx = S_PRE;
          n_ras_nx = '1;
          n_cas_nx = 1'b1;
          n_lwe_nx = 1'b1;
          n_uwe_nx = 1'b1;
          rasel_nx = 1'b0;
        end
      end
      S_REF_CAS: begin
        state_nx = S_REF_RAS;
        n_ras_nx = '0;
      end
      S_REF_RAS: begin
        if (cnt == CW'(TRAS-1)) begin
          state_nx = S_PRE;
          n_ras_nx = '1;
          n_cas_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_PRE: begin
        if (cnt == CW'(TRP-1)) begin
          state_nx = S_IDLE;
          ready_nx = (pend_nx < PW'(REFURG));
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
    n_oe_nx = (state_nx inside {S_ROW, S_COL, S_HOLD}) ? !(bact && ramcs && n_we) : 1'b1;
    ra_nx   = rasel_nx ? col : row;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tmr       <= '0;
      ref_pend  <= '0;
      dtack_r   <= 1'b0;
      rasel     <= 1'b0;
      n_ras     <= '1;
      n_cas     <= 1'b1;
      n_lwe     <= 1'b1;
      n_uwe     <= 1'b1;
      n_oe      <= 1'b1;
      ram_ready <= 1'b1;
      ra        <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      tmr       <= tick ? '0 : tmr + TW'(1);
      ref_pend  <= pend_nx;
      dtack_r   <= !n_dtack;
      rasel     <= rasel_nx;
      n_ras     <= n_ras_nx;
      n_cas     <= n_cas_nx;
      n_lwe     <= n_lwe_nx;
      n_uwe     <= n_uwe_nx;
      n_oe      <= n_oe_nx;
      ram_ready <= ready_nx;
      ra        <= ra_nx;
    end
  end

endmodule

// File: tb/tb_dram_ctrl_gen2.sv
// Directed bench for dram_ctrl_gen2 (REFDIV=8): reads, byte write, CBR refresh,
// urgent refresh under continuous traffic, counter saturation and reset mid-cycle.
module tb_dram_ctrl_gen2;

  localparam int unsigned REFMAX = 4;
  localparam int unsigned REFURG = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [20:0] a;
  logic        n_we, n_as, n_lds, n_uds, n_dtack, bact, ramcs;
  logic [9:0]  ra;
  logic [1:0]  n_ras;
  logic        n_cas, n_lwe, n_uwe, n_oe, ram_ready;
  logic [2:0]  ref_pend;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] ras;
    logic       cas, lwe, uwe, oe, rdy;
    logic [2:0] pend;
    logic [9:0] ra;
    bit         ra_chk;
  } exp_t;

  exp_t exp_q[$];

  dram_ctrl_gen2 #(.RAW(10), .BANKW(1), .REFDIV(8), .REFMAX(REFMAX), .REFURG(REFURG),
                   .TRAS(2), .TRP(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .n_we(n_we), .n_as(n_as), .n_lds(n_lds),
    .n_uds(n_uds), .n_dtack(n_dtack), .bact(bact), .ramcs(ramcs), .ra(ra),
    .n_ras(n_ras), .n_cas(n_cas), .n_lwe(n_lwe), .n_uwe(n_uwe), .n_oe(n_oe),
    .ram_ready(ram_ready), .ref_pend(ref_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue the expected outputs, advance one clock, then compare against the queue head
  task automatic step(input string tag, input logic [1:0] ras, input logic cas, input logic lwe,
                      input logic uwe, input logic oe, input logic rdy, input logic [2:0] pend,
                      input logic [9:0] ra_v, input bit ra_chk);
    exp_t e;
    e.tag = tag; e.ras = ras; e.cas = cas; e.lwe = lwe; e.uwe = uwe; e.oe = oe;
    e.rdy = rdy; e.pend = pend; e.ra = ra_v; e.ra_chk = ra_chk;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.tag, "_ras"},  32'(n_ras),     32'(e.ras));
    chk({e.tag, "_cas"},  32'(n_cas),     32'(e.cas));
    chk({e.tag, "_lwe"},  32'(n_lwe),     32'(e.lwe));
    chk({e.tag, "_uwe"},  32'(n_uwe),     32'(e.uwe));
    chk({e.tag, "_oe"},   32'(n_oe),      32'(e.oe));
    chk({e.tag, "_rdy"},  32'(ram_ready), 32'(e.rdy));
    chk({e.tag, "_pend"}, 32'(ref_pend),  32'(e.pend));
    if (e.ra_chk) chk({e.tag, "_ra"}, 32'(ra), 32'(e.ra));
  endtask

  task automatic bus_idle();
    bact = 1'b0; ramcs = 1'b0; n_as = 1'b1; n_dtack = 1'b1;
    n_we = 1'b1; n_lds = 1'b1; n_uds = 1'b1;
  endtask

  initial begin
    bit prev_idle, idle_now, urg, found;
    int nref, nurg, maxp;

    rst_n = 1'b0; a = '0;
    bus_idle();
    repeat (2) @(negedge clk);
    chk("rst_ras",  32'(n_ras), 32'h3);
    chk("rst_cas",  32'(n_cas), 32'h1);
    chk("rst_we",   32'({n_lwe, n_uwe}), 32'h3);
    chk("rst_oe",   32'(n_oe), 32'h1);
    chk("rst_rdy",  32'(ram_ready), 32'h1);
    chk("rst_pend", 32'(ref_pend), 32'h0);

    // Read bank 1, row 0x155, column 0x2AA
    rst_n = 1'b1;
    a = {1'b1, 10'h155, 10'h2AA};
    bact = 1'b1; ramcs = 1'b1; n_as = 1'b0; n_we = 1'b1;
    step("rd_row",  2'b01, 1, 1, 1, 0, 1, 0, 10'h155, 1);
    step("rd_col",  2'b01, 0, 1, 1, 0, 1, 0, 10'h2AA, 1);
    step("rd_hold", 2'b01, 0, 1, 1, 0, 1, 0, 10'h2AA, 1);
    n_dtack = 1'b0;
    step("rd_dtr",  2'b01, 0, 1, 1, 0, 1, 0, 10'h2AA, 1);
    step("rd_rel",  2'b11, 1, 1, 1, 1, 1, 0, 10'h000, 0);
    bus_idle();
    step("rd_pre",  2'b11, 1, 1, 1, 1, 1, 0, 10'h000, 0);
    step("idle0",   2'b11, 1, 1, 1, 1, 1, 0, 10'h000, 0);
    step("tick0",   2'b11, 1, 1, 1, 1, 1, 1, 10'h000, 0);

    // Idle bus: CBR refresh every 8 cycles
    for (int r = 0; r < 2; r++) begin
      step("cbr_cas",  2'b11, 0, 1, 1, 1, 0, 1, 10'h000, 0);
      step("cbr_ras0", 2'b00, 0, 1, 1, 1, 0, 0, 10'h000, 0);
      step("cbr_ras1", 2'b00, 0, 1, 1, 1, 0, 0, 10'h000, 0);
      step("cbr_pre0", 2'b11, 1, 1, 1, 1, 0, 0, 10'h000, 0);
      step("cbr_pre1", 2'b11, 1, 1, 1, 1, 0, 0, 10'h000, 0);
      step("cbr_idle", 2'b11, 1, 1, 1, 1, 1, 0, 10'h000, 0);
      if (r == 0) begin
        step("idle1", 2'b11, 1, 1, 1, 1, 1, 0, 10'h000, 0);
        step("tick1", 2'b11, 1, 1, 1, 1, 1, 1, 10'h000, 0);
      end
    end

    // Low-byte write to bank 0, row 0x0AA, column 0x155
    a = {1'b0, 10'h0AA, 10'h155};
    bact = 1'b1; ramcs = 1'b1; n_as = 1'b0; n_we = 1'b0; n_lds = 1'b0; n_uds = 1'b1;
    step("wr_row",   2'b10, 1, 1, 1, 1, 1, 0, 10'h0AA, 1);
    step("wr_col",   2'b10, 0, 0, 1, 1, 1, 1, 10'h155, 1);
    step("wr_hold",  2'b10, 0, 0, 1, 1, 1, 1, 10'h155, 1);
    step("wr_hold2", 2'b10, 0, 0, 1, 1, 1, 1, 10'h155, 1);
    n_dtack = 1'b0;
    step("wr_dtr",   2'b10, 0, 0, 1, 1, 1, 1, 10'h155, 1);
    step("wr_rel",   2'b11, 1, 1, 1, 1, 1, 1, 10'h000, 0);
    bus_idle();
    step("wr_pre",   2'b11, 1, 1, 1, 1, 1, 1, 10'h000, 0);
    step("wr_idle",  2'b11, 1, 1, 1, 1, 1, 1, 10'h000, 0);
    step("t5_cas",   2'b11, 0, 1, 1, 1, 0, 1, 10'h000, 0);
    // Tick lands on the same edge as the refresh /RAS entry
    step("t5_coinc", 2'b00, 0, 1, 1, 1, 0, 1, 10'h000, 0);
    step("t5_ras1",  2'b00, 0, 1, 1, 1, 0, 1, 10'h000, 0);
    step("t5_pre",   2'b11, 1, 1, 1, 1, 0, 1, 10'h000, 0);

    // Continuous reads: once refresh is urgent it must precede the next access
    a = {1'b0, 10'h3FF, 10'h001};
    bact = 1'b1; ramcs = 1'b1; n_as = 1'b0; n_we = 1'b1;
    prev_idle = 1'b1; urg = 1'b0; nref = 0; nurg = 0; maxp = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      @(negedge clk);
      idle_now = (n_ras == 2'b11) && n_cas;
      if (prev_idle && !idle_now) begin
        if (urg) chk("urg_first", 32'(n_ras), 32'h3);
        if (n_ras == 2'b11) begin
          nref++;
          urg = 1'b0;
          chk("urg_rdy", 32'(ram_ready), 32'h0);
        end
      end
      if ((ref_pend >= 3'(REFURG)) && !((n_ras == 2'b11) && !n_cas)) begin
        urg = 1'b1;
        nurg++;
      end
      if (int'(ref_pend) > maxp) maxp = int'(ref_pend);
      if (!n_cas && (n_ras != 2'b11)) n_dtack = 1'b0;
      else if (idle_now) n_dtack = 1'b1;
      prev_idle = idle_now;
    end
    chk("ref_seen", 32'(nref != 0), 32'h1);
    chk("urg_seen", 32'(nurg != 0), 32'h1);
    chk("pend_max", 32'(maxp <= int'(REFMAX)), 32'h1);

    // Stall an access in HOLD until the pending count saturates
    n_dtack = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (!n_cas && (n_ras != 2'b11)) found = 1'b1;
    end
    chk("wait_hold", 32'(found), 32'h1);
    repeat (40) @(negedge clk);
    chk("pend_sat", 32'(ref_pend), 32'(REFMAX));
    chk("hold_ras", 32'(n_ras), 32'h2);

    // Asynchronous reset in the middle of HOLD
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ras",  32'(n_ras), 32'h3);
    chk("arst_cas",  32'(n_cas), 32'h1);
    chk("arst_we",   32'({n_lwe, n_uwe}), 32'h3);
    chk("arst_oe",   32'(n_oe), 32'h1);
    chk("arst_pend", 32'(ref_pend), 32'h0);
    chk("arst_rdy",  32'(ram_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_idle();
    step("prst_idle0", 2'b11, 1, 1, 1, 1, 1, 0, 10'h000, 0);
    step("prst_idle1", 2'b11, 1, 1, 1, 1, 1, 0, 10'h000, 0);
    bact = 1'b1; ramcs = 1'b1; n_as = 1'b0;
    step("prst_row",   2'b10, 1, 1, 1, 0, 1, 0, 10'h3FF, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
